// File: rtl/alu_pkg.sv
// Shared definitions for the Mini SRC ALU: divider FSM states, iteration count,
// divide-by-zero quotient and HI/LO slice positions common to multiplier and divider.
package alu_pkg;

    localparam int ALU_WIDTH = 32;
    localparam int DIV_ITERS = ALU_WIDTH;

    localparam logic [ALU_WIDTH-1:0] DIV_ZERO_QUOTIENT = '1;

    // HI holds the remainder (or product upper half), LO the quotient (or lower half).
    localparam int LO_LSB = 0;
    localparam int LO_MSB = ALU_WIDTH - 1;
    localparam int HI_LSB = ALU_WIDTH;
    localparam int HI_MSB = 2 * ALU_WIDTH - 1;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        ITER,
        FIXUP,
        DONE
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, q} left, trial-subtract the divisor,
// keep the difference and set the quotient bit when it does not go negative.
module div_step
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH:0]   divisor,
    output logic [WIDTH:0]   rem_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH+1:0] rem_shift;
    logic [WIDTH+1:0] trial;

    // One extra bit on the trial so an unsigned divisor near 2^WIDTH still yields a clean sign.
    always_comb begin
        rem_shift = {rem, q[WIDTH-1]};
        trial     = rem_shift - {1'b0, divisor};
        if (trial[WIDTH+1]) begin
            rem_next = rem_shift[WIDTH:0];
            q_next   = {q[WIDTH-2:0], 1'b0};
        end else begin
            rem_next = trial[WIDTH:0];
            q_next   = {q[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/booth_divider_seq.sv
// Sequential signed divider producing {remainder, quotient} for HI/LO, one bit per cycle.
// Optional macro DIVIDER_UNSIGNED_EN adds an unsigned_op input for unsigned division.
module booth_divider_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = DIV_ITERS
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
`ifdef DIVIDER_UNSIGNED_EN
    input  logic                 unsigned_op,
`endif
    output logic                 busy,
    output logic                 done,
    output logic                 div_by_zero,
    output logic [2*WIDTH-1:0]   RESULT
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    div_state_t state_reg, state_next;

    logic [WIDTH-1:0]   a_reg, b_reg;
    logic               uns_op_reg;
    logic               sign_q_reg, sign_r_reg;
    logic               zero_div_reg;
    logic [WIDTH:0]     rem_reg;
    logic [WIDTH-1:0]   q_reg;
    logic [WIDTH:0]     divisor_reg;
    logic [CW-1:0]      count_reg;
    logic [2*WIDTH-1:0] result_reg;
    logic               div_by_zero_reg;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH-1:0]   q_fix, rem_fix;
    logic [WIDTH:0]     step_rem;
    logic [WIDTH-1:0]   step_q;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_reg),
        .q        (q_reg),
        .divisor  (divisor_reg),
        .rem_next (step_rem),
        .q_next   (step_q)
    );

    always_ff @(posedge clock) begin
        if (clear) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // The zero-divisor path also passes through FIXUP so RESULT is written in one place.
    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = PREP;
                end
            end
            PREP: begin
                busy       = 1'b1;
                state_next = (b_reg == '0) ? FIXUP : ITER;
            end
            ITER: begin
                busy = 1'b1;
                if (count_reg == LAST_ITER) begin
                    state_next = FIXUP;
                end
            end
            FIXUP: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        a_neg   = ~uns_op_reg & a_reg[WIDTH-1];
        b_neg   = ~uns_op_reg & b_reg[WIDTH-1];
        a_mag   = a_neg ? -a_reg : a_reg;
        b_mag   = b_neg ? -b_reg : b_reg;
        q_fix   = sign_q_reg ? -q_reg : q_reg;
        rem_fix = sign_r_reg ? -rem_reg[WIDTH-1:0] : rem_reg[WIDTH-1:0];
    end

`ifdef DIVIDER_UNSIGNED_EN
    always_ff @(posedge clock) begin
        if (clear) begin
            uns_op_reg <= 1'b0;
        end else if (state_reg == IDLE && start) begin
            uns_op_reg <= unsigned_op;
        end
    end
`else
    assign uns_op_reg = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (clear) begin
            a_reg           <= '0;
            b_reg           <= '0;
            sign_q_reg      <= 1'b0;
            sign_r_reg      <= 1'b0;
            zero_div_reg    <= 1'b0;
            rem_reg         <= '0;
            q_reg           <= '0;
            divisor_reg     <= '0;
            count_reg       <= '0;
            result_reg      <= '0;
            div_by_zero_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_reg <= A;
                        b_reg <= B;
                    end
                end
                PREP: begin
                    sign_q_reg   <= a_neg ^ b_neg;
                    sign_r_reg   <= a_neg;
                    q_reg        <= a_mag;
                    divisor_reg  <= {1'b0, b_mag};
                    rem_reg      <= '0;
                    count_reg    <= '0;
                    zero_div_reg <= (b_reg == '0);
                end
                ITER: begin
                    rem_reg   <= step_rem;
                    q_reg     <= step_q;
                    count_reg <= count_reg + CW'(1);
                end
                FIXUP: begin
                    if (zero_div_reg) begin
                        result_reg <= {a_reg, {WIDTH{1'b1}}};
                    end else begin
                        result_reg <= {rem_fix, q_fix};
                    end
                    div_by_zero_reg <= zero_div_reg;
                end
                default: begin
                end
            endcase
        end
    end

    assign div_by_zero = div_by_zero_reg;
    assign RESULT      = result_reg;

endmodule

// File: tb/tb_booth_divider_seq.sv
// Directed and randomised checks of booth_divider_seq: reset, signed cases, overflow,
// divide-by-zero, ignored restart, mid-operation clear, back-to-back launches.
module tb_booth_divider_seq;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic        start = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [63:0] RESULT;
`ifdef DIVIDER_UNSIGNED_EN
    logic        unsigned_op = 1'b0;
`endif

    int tests = 0;
    int failed = 0;
    int done_total = 0;

    booth_divider_seq dut (
`ifdef DIVIDER_UNSIGNED_EN
        .unsigned_op (unsigned_op),
`endif
        .clock       (clock),
        .clear       (clear),
        .start       (start),
        .A           (A),
        .B           (B),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .RESULT      (RESULT)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (done === 1'b1) done_total++;
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests++;
        assert (observed === expected) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Called at a negedge; returns at the negedge after done, i.e. in IDLE.
    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_q, input logic [31:0] exp_r,
                           input logic exp_dz, input int exp_lat);
        int lat;
        bit seen;
        lat  = 0;
        seen = 0;
        A = a;
        B = b;
        start = 1'b1;
        while (!seen && lat < 60) begin
            @(posedge clock);
            lat++;
            @(negedge clock);
            start = 1'b0;
            if (done === 1'b1) seen = 1;
        end
        check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
        check({tag, ".quotient"}, {32'h0, RESULT[31:0]}, {32'h0, exp_q});
        check({tag, ".remainder"}, {32'h0, RESULT[63:32]}, {32'h0, exp_r});
        check({tag, ".div_by_zero"}, {63'h0, div_by_zero}, {63'h0, exp_dz});
        check({tag, ".busy_at_done"}, {63'h0, busy}, 64'h0);
        @(negedge clock);
        check({tag, ".done_pulse"}, {63'h0, done}, 64'h0);
    endtask

    initial begin
        int lat;
        int n0;
        bit seen;
        logic [31:0] ra, rb;
        int sa, sb;

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset.busy", {63'h0, busy}, 64'h0);
        check("reset.done", {63'h0, done}, 64'h0);
        check("reset.dz", {63'h0, div_by_zero}, 64'h0);
        check("reset.result", RESULT, 64'h0);
        clear = 1'b0;
        @(negedge clock);

        run_div("p100_7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 35);
        run_div("m100_7", 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 35);
        run_div("p100_m7", 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2, 1'b0, 35);
        run_div("overflow", 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0, 1'b0, 35);
        run_div("div0_pos", 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b0 | 1'b1, 3);
        run_div("div0_neg", 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1, 3);
        run_div("m9_2", 32'hFFFFFFF7, 32'd2, 32'hFFFFFFFC, 32'hFFFFFFFF, 1'b0, 35);
        run_div("small_a", 32'd7, 32'd100, 32'd0, 32'd7, 1'b0, 35);
        run_div("m1_1", 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, 35);
        run_div("max_min", 32'h7FFFFFFF, 32'h80000000, 32'd0, 32'h7FFFFFFF, 1'b0, 35);
        run_div("min_2", 32'h80000000, 32'd2, 32'hC0000000, 32'd0, 1'b0, 35);
        run_div("m8_m3", 32'hFFFFFFF8, 32'hFFFFFFFD, 32'd2, 32'hFFFFFFFE, 1'b0, 35);

        // Restart attempt with new operands while busy must be ignored.
        n0 = done_total;
        lat = 0;
        seen = 0;
        A = 32'd100;
        B = 32'd7;
        start = 1'b1;
        while (!seen && lat < 60) begin
            @(posedge clock);
            lat++;
            @(negedge clock);
            start = 1'b0;
            if (lat == 10) begin
                check("ignore.busy_mid", {63'h0, busy}, 64'h1);
                A = 32'd9;
                B = 32'd2;
                start = 1'b1;
            end
            if (done === 1'b1) seen = 1;
        end
        check("ignore.latency", 64'(lat), 64'd35);
        check("ignore.quotient", {32'h0, RESULT[31:0]}, 64'd14);
        check("ignore.remainder", {32'h0, RESULT[63:32]}, 64'd2);
        @(negedge clock);
        check("ignore.done_count", 64'(done_total - n0), 64'd1);

        // Clear in the middle of an operation abandons it.
        A = 32'd100;
        B = 32'd7;
        start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock);
            @(negedge clock);
            start = 1'b0;
        end
        clear = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("clear.busy", {63'h0, busy}, 64'h0);
        check("clear.done", {63'h0, done}, 64'h0);
        check("clear.result", RESULT, 64'h0);
        check("clear.dz", {63'h0, div_by_zero}, 64'h0);
        clear = 1'b0;
        n0 = done_total;
        repeat (40) @(negedge clock);
        check("clear.no_done", 64'(done_total - n0), 64'd0);
        run_div("after_clear", 32'd9, 32'd2, 32'd4, 32'd1, 1'b0, 35);

        // Random signed pairs against the language's truncating division.
        for (int i = 0; i < 80; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 3 == 0) rb = 32'($urandom_range(1, 40));
            if (i % 4 == 1) rb = -rb;
            if (i % 5 == 2) ra = 32'($urandom_range(0, 1000));
            if (rb == 32'h0) rb = 32'd1;
            if (ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd3;
            sa = ra;
            sb = rb;
            run_div($sformatf("rand%0d", i), ra, rb, 32'(sa / sb), 32'(sa % sb), 1'b0, 35);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
